rv_trace_encoder: RTL and testbench
===================================

# rv_trace_encoder

Synthesizable retirement-trace transmitter for the FlexRV32 core. It taps the writeback stage and captures one record per retired instruction: PC, opcode, register write-back and memory access. Records are buffered in a small FIFO and serialized LSB-first as variable-length byte packets on a valid/ready stream. The stream feeds a debug UART or host bridge, whose software decodes it into the same trace text the simulator trace produces.

## Interface
- IADDR_SPACE_BITS, 32, instruction address width; PC is zero-extended to 32 bits in packets.
- FIFO_DEPTH, 4, record FIFO entries; power of two, ≥2.

- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  capture enable; low blocks new pushes, queued records still drain.
- i_retire  in  1  one instruction retires this cycle; qualifies all capture inputs.
- i_pc  in  IADDR_SPACE_BITS-1  retired PC bits [IADDR_SPACE_BITS-1:1]; bit 0 is implied 0.
- i_instr  in  32  retired opcode.
- i_reg_write, i_reg_data  in  1, 32  register write-back flag and value.
- i_mem_read, i_mem_write  in  1, 1  memory access flags.
- i_mem_addr, i_mem_data  in  32, 32  memory address and load/store data.
- o_data  out  8  stream byte.
- o_valid  out  1  o_data valid.
- i_ready  in  1  sink accepts the byte; a byte transfers when o_valid && i_ready.
- o_overflow  out  1  sticky: at least one record was dropped since reset.
- o_busy  out  1  FIFO non-empty or a packet is in progress.

## Operation
- **Push condition.** Push when i_retire && i_enable && (count<FIFO_DEPTH || pop this cycle).
- **Drop.** If i_retire && i_enable and no push is possible, the record is dropped. o_overflow is set, and lost_pending is set.
- **Lost flag.** The next pushed record stores lost=lost_pending; lost_pending clears on that push.
- **Header byte.** bit7=1 (sync), bit6=lost, bit5=reg_write, bit4=mem_read, bit3=mem_write, bits2:0=0.
- **Packet body, in order, each 32-bit field LSB byte first:**
  - PC: 4 bytes.
  - INSTR: 4 bytes.
  - RD: 4 bytes, only if reg_write.
  - ADDR: 4 bytes, then DATA: 4 bytes, only if mem_read || mem_write.
- **Packet lengths.** 9, 13, 17 or 21 bytes.
- **FSM states.** IDLE, HDR, PC, INSTR, RD, ADDR, DATA, with a 2-bit byte index.
- **IDLE.** Goes to HDR when the FIFO is non-empty.
- **Field advance.** On each handshake in a 4-byte field, the index increments. On index 3 the FSM moves to the next present field.
- **Packet end.** On the last byte: pop the head entry. Go to HDR if entries remain after the pop, otherwise go to IDLE.
- **o_data.** Combinational mux of the head entry, state and byte index. It is held stable while o_valid && !i_ready.
- **o_valid.** High in every state except IDLE.
- **Reset.** All state clears asynchronously: FIFO pointers and count, FSM=IDLE, index=0, lost_pending=0. Outputs: o_valid=0, o_overflow=0, o_busy=0, o_data=0. Reset mid-packet abandons the packet and no partial recovery is attempted.

## Timing
- **Retire-to-stream latency.** i_retire in cycle 0 writes the FIFO at the end of cycle 0. The FSM enters HDR at the end of cycle 1, and o_valid is first high in cycle 2.
- **Throughput.** One byte per cycle with i_ready held high. Packets are back-to-back: the header of the next packet follows the last byte of the previous one with no idle cycle.
- **Full FIFO with pop.** When count==FIFO_DEPTH and the final byte is accepted in the same cycle as i_retire, the new record is pushed, not dropped.
- **Push into empty FIFO.** A push while the FIFO is empty and the FSM is IDLE does not shorten latency below 2 cycles.
- **i_enable deassert mid-packet.** Has no effect on transmission.

## Test plan
- **Single ALU retire.** i_pc=0x40 (PC 0x80), i_instr=0x00500093, reg_write=1, i_reg_data=5, i_ready=1. Expect o_valid from cycle 2, then 13 bytes: A0 80 00 00 00 93 00 50 00 05 00 00 00. Then IDLE, o_busy=0.
- **Store.** sw, PC 0x100, mem_write=1, addr 0x2000, data 0xDEADBEEF. Expect header 0x88, then PC, INSTR, 00 20 00 00, EF BE AD DE; 17 bytes total.
- **Backpressure.** Load with reg_write (21 bytes), i_ready toggling 1,0,0,1 repeatedly. Expect o_data stable while stalled and the exact byte sequence. The final handshake occurs on the 21st accepted byte.
- **Overflow.**
  - Stimulus: FIFO_DEPTH=4, i_ready=0, 6 consecutive retires, then i_ready=1 plus a 7th retire after the drain.
  - Expect: 4 packets with bit6=0; the 7th packet's header has bit6=1; o_overflow=1 from the 5th retire onward.
- **Full-with-pop boundary.** FIFO full, and i_retire asserted in the cycle the last byte is accepted. Expect the record queued with no drop and o_overflow unchanged.
- **Reset mid-packet.** Assert i_reset during byte 5. Expect o_valid=0 immediately and o_busy=0. After release, a new retire produces a complete packet starting with its header.

Source files
------------

// File: rtl/rv_trace_encoder.sv
// Retirement-trace transmitter: buffers one record per retired instruction and
// serializes it LSB-first as a 9/13/17/21-byte packet on a valid/ready byte stream.
module rv_trace_encoder #(
    parameter int unsigned IADDR_SPACE_BITS = 32,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_retire,
    input  logic [IADDR_SPACE_BITS-1:1] i_pc,
    input  logic [31:0]                 i_instr,
    input  logic                        i_reg_write,
    input  logic [31:0]                 i_reg_data,
    input  logic                        i_mem_read,
    input  logic                        i_mem_write,
    input  logic [31:0]                 i_mem_addr,
    input  logic [31:0]                 i_mem_data,
    output logic [7:0]                  o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_overflow,
    output logic                        o_busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic        lost;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PC, S_INSTR, S_RD, S_ADDR, S_DATA
    } state_t;

    rec_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             lost_pending;
    state_t           state;
    logic [1:0]       idx;

    rec_t       rec_in;
    rec_t       head;
    logic       has_mem;
    logic       fire;
    logic       last_field;
    logic       pop;
    logic       capture;
    logic       push;
    state_t     end_state;
    state_t     next_field;
    logic [7:0] header;
    logic [31:0] word;

    always_comb begin
        rec_in.lost      = lost_pending;
        rec_in.reg_write = i_reg_write;
        rec_in.mem_read  = i_mem_read;
        rec_in.mem_write = i_mem_write;
        rec_in.pc        = 32'({i_pc, 1'b0});
        rec_in.instr     = i_instr;
        rec_in.rd        = i_reg_data;
        rec_in.addr      = i_mem_addr;
        rec_in.data      = i_mem_data;
    end

    assign head    = fifo_mem[rd_ptr];
    assign has_mem = head.mem_read | head.mem_write;
    assign o_valid = (state != S_IDLE);
    assign o_busy  = (count != '0) || (state != S_IDLE);
    assign fire    = o_valid && i_ready;

    // A packet ends on the final byte of its last present field.
    assign last_field = ((state == S_INSTR) && !head.reg_write && !has_mem) ||
                        ((state == S_RD) && !has_mem) ||
                        (state == S_DATA);
    assign pop     = fire && (idx == 2'd3) && last_field;
    assign capture = i_retire && i_enable;
    assign push    = capture && ((count < CNT_W'(FIFO_DEPTH)) || pop);

    // Only entries already queued keep the stream back-to-back; a same-cycle push waits in IDLE.
    assign end_state = (count > CNT_W'(1)) ? S_HDR : S_IDLE;

    always_comb begin
        next_field = end_state;
        unique case (state)
            S_PC:    next_field = S_INSTR;
            S_INSTR: next_field = head.reg_write ? S_RD : (has_mem ? S_ADDR : end_state);
            S_RD:    next_field = has_mem ? S_ADDR : end_state;
            S_ADDR:  next_field = S_DATA;
            default: next_field = end_state;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= rec_in;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            lost_pending <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr       <= wr_ptr + PTR_W'(1);
                lost_pending <= 1'b0;
            end else if (capture) begin
                lost_pending <= 1'b1;
                o_overflow   <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Packet sequencer: header, then each present 4-byte field.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
            idx   <= 2'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    idx <= 2'd0;
                    if (count != '0) begin
                        state <= S_HDR;
                    end
                end
                S_HDR: begin
                    idx <= 2'd0;
                    if (fire) begin
                        state <= S_PC;
                    end
                end
                default: begin
                    if (fire) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state <= next_field;
                        end
                    end
                end
            endcase
        end
    end

    assign header = {1'b1, head.lost, head.reg_write, head.mem_read, head.mem_write, 3'b000};

    always_comb begin
        word = 32'd0;
        unique case (state)
            S_HDR:   word = {24'd0, header};
            S_PC:    word = head.pc;
            S_INSTR: word = head.instr;
            S_RD:    word = head.rd;
            S_ADDR:  word = head.addr;
            S_DATA:  word = head.data;
            default: word = 32'd0;
        endcase
        o_data = 8'(word >> {idx, 3'b000});
    end

endmodule

// File: tb/tb_rv_trace_encoder.sv
// Self-checking bench for rv_trace_encoder: directed scenarios plus randomized
// traffic against a queue-based packet model.
module tb_rv_trace_encoder;

    localparam int unsigned DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        enable;
    logic        retire;
    logic [31:1] pc_in;
    logic [31:0] instr;
    logic        reg_write;
    logic [31:0] reg_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        ready;
    logic        o_overflow;
    logic        o_busy;

    rv_trace_encoder #(.IADDR_SPACE_BITS(32), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(enable), .i_retire(retire),
        .i_pc(pc_in), .i_instr(instr), .i_reg_write(reg_write), .i_reg_data(reg_data),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_addr(mem_addr),
        .i_mem_data(mem_data), .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
        .o_overflow(o_overflow), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: expected byte stream and remaining length of each queued packet.
    logic [7:0] exp_q [$];
    int         len_q [$];
    logic [7:0] got_q [$];
    logic       m_lost = 1'b0;
    logic       m_ovf  = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       valid_s;

    logic [7:0] alu_b [13] = '{8'hA0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                               8'h50, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    logic [7:0] st_b [8] = '{8'h00, 8'h20, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
    endtask

    task automatic model_push();
        int n;
        n = 9;
        exp_q.push_back({1'b1, m_lost, reg_write, mem_read, mem_write, 3'b000});
        push_word({pc_in, 1'b0});
        push_word(instr);
        if (reg_write) begin push_word(reg_data); n += 4; end
        if (mem_read || mem_write) begin push_word(mem_addr); push_word(mem_data); n += 8; end
        len_q.push_back(n);
        m_lost = 1'b0;
    endtask

    task automatic set_rec(input logic [31:0] pc, input logic [31:0] ins, input logic rw,
                           input logic [31:0] rd, input logic mr, input logic mw,
                           input logic [31:0] ad, input logic [31:0] dt);
        pc_in = pc[31:1]; instr = ins; reg_write = rw; reg_data = rd;
        mem_read = mr; mem_write = mw; mem_addr = ad; mem_data = dt;
    endtask

    // One clock cycle: drive, sample mid-low-phase, score the handshake, advance model.
    task automatic tick(input logic ret, input logic rdy);
        logic pop_now;
        retire = ret;
        ready  = rdy;
        #1;
        if (prev_stall) check("hold", 32'(o_data), 32'(prev_data));
        check("busy", 32'(o_busy), 32'(len_q.size() != 0));
        check("ovf", 32'(o_overflow), 32'(m_ovf));
        if (len_q.size() == 0) check("valid_idle", 32'(o_valid), 32'd0);
        valid_s = o_valid;
        pop_now = 1'b0;
        if (o_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("extra_byte", 32'(o_data), 32'hFFFF_FFFF);
            end else begin
                got_q.push_back(o_data);
                check("byte", 32'(o_data), 32'(exp_q.pop_front()));
                len_q[0] = len_q[0] - 1;
                if (len_q[0] == 0) begin
                    void'(len_q.pop_front());
                    pop_now = 1'b1;
                end
            end
        end
        prev_stall = o_valid && !rdy;
        prev_data  = o_data;
        if (ret && enable) begin
            if (len_q.size() < DEPTH || pop_now) model_push();
            else begin m_lost = 1'b1; m_ovf = 1'b1; end
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (len_q.size() != 0 && n < 400) begin
            tick(1'b0, 1'b1);
            n++;
        end
        check(tag, 32'(len_q.size()), 32'd0);
    endtask

    initial begin
        int  n;
        logic done;
        logic r;
        i_reset = 1'b1; enable = 1'b1; retire = 1'b0; ready = 1'b0;
        set_rec(32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge i_clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);

        // Single ALU retire with exact latency and byte image.
        got_q.delete();
        set_rec(32'h80, 32'h0050_0093, 1'b1, 32'd5, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 1'b1);
        check("lat_c0", 32'(valid_s), 32'd0);
        tick(1'b0, 1'b1);
        check("lat_c1", 32'(valid_s), 32'd0);
        tick(1'b0, 1'b1);
        check("lat_c2", 32'(valid_s), 32'd1);
        drain("alu_drain");
        check("alu_len", 32'(got_q.size()), 32'd13);
        for (int i = 0; i < 13 && i < got_q.size(); i++) check("alu_byte", 32'(got_q[i]), 32'(alu_b[i]));
        tick(1'b0, 1'b1);
        check("alu_busy", 32'(o_busy), 32'd0);

        // Store packet.
        got_q.delete();
        set_rec(32'h100, 32'h00A1_2023, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 32'hDEAD_BEEF);
        tick(1'b1, 1'b1);
        drain("st_drain");
        check("st_len", 32'(got_q.size()), 32'd17);
        if (got_q.size() == 17) begin
            check("st_hdr", 32'(got_q[0]), 32'h88);
            for (int i = 0; i < 8; i++) check("st_body", 32'(got_q[9+i]), 32'(st_b[i]));
        end

        // Load with reg write under 1,0,0,1 backpressure.
        got_q.delete();
        set_rec(32'h204, 32'h0041_2283, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h3000, 32'h1234_5678);
        tick(1'b1, 1'b1);
        n = 1;
        while (len_q.size() != 0 && n < 200) begin
            tick(1'b0, (n % 4 == 0) || (n % 4 == 3));
            n++;
        end
        check("bp_drain", 32'(len_q.size()), 32'd0);
        check("bp_len", 32'(got_q.size()), 32'd21);
        if (got_q.size() != 0) check("bp_hdr", 32'(got_q[0]), 32'hB0);

        // Full FIFO with the final byte accepted in the same cycle as a retire.
        got_q.delete();
        set_rec(32'h400, 32'h0000_0013, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        done = 1'b0;
        n = 0;
        while (len_q.size() != 0 && n < 200) begin
            r = !done && (len_q.size() == DEPTH) && (len_q[0] == 1);
            tick(r, 1'b1);
            if (r) done = 1'b1;
            n++;
        end
        check("fwp_hit", 32'(done), 32'd1);
        check("fwp_ovf", 32'(o_overflow), 32'd0);
        check("fwp_len", 32'(got_q.size()), 32'd45);

        // Overflow: six retires into a stalled stream, then one more after draining.
        got_q.delete();
        for (int i = 0; i < 6; i++) begin
            set_rec(32'h800 + 32'(4*i), 32'h0000_0013, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            tick(1'b1, 1'b0);
            #1;
            if (i == 3) check("ovf_after4", 32'(o_overflow), 32'd0);
            if (i >= 4) check("ovf_set", 32'(o_overflow), 32'd1);
        end
        drain("ovf_drain");
        set_rec(32'h900, 32'h0000_0013, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 1'b1);
        drain("ovf_drain7");
        check("ovf_len", 32'(got_q.size()), 32'd45);
        if (got_q.size() == 45) begin
            for (int p = 0; p < 4; p++) check("ovf_lost0", 32'(got_q[9*p][6]), 32'd0);
            check("ovf_lost7", 32'(got_q[36][6]), 32'd1);
        end

        // Reset during byte 5 of a packet.
        got_q.delete();
        set_rec(32'hA00, 32'h0000_0013, 1'b1, 32'h77, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 1'b1);
        n = 0;
        while (got_q.size() < 4 && n < 20) begin tick(1'b0, 1'b1); n++; end
        check("mid_pre", 32'(got_q.size()), 32'd4);
        i_reset = 1'b1;
        #1;
        check("mid_valid", 32'(o_valid), 32'd0);
        check("mid_busy", 32'(o_busy), 32'd0);
        check("mid_ovf", 32'(o_overflow), 32'd0);
        exp_q.delete(); len_q.delete();
        m_lost = 1'b0; m_ovf = 1'b0; prev_stall = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        got_q.delete();
        set_rec(32'hB00, 32'h0000_0013, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 1'b1);
        drain("mid_drain");
        check("mid_len", 32'(got_q.size()), 32'd9);
        if (got_q.size() != 0) check("mid_hdr", 32'(got_q[0]), 32'h80);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            set_rec($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
        end
        enable = 1'b1;
        drain("rnd_drain");
        check("rnd_empty", 32'(exp_q.size()), 32'd0);
        tick(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
